// File: rtl/sorter_pkg.sv
// sorter_pkg: defaults and slot-slicing helpers shared by the compare-and-swap
// stages and the merge units.
`default_nettype none

package sorter_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_N_LANES     = 4;
  localparam int DEF_INDEX_WIDTH = 3;
  localparam int DEF_SIGNED_KEYS = 0;

  // Slot number of element A (is_b=0) or B (is_b=1) of a lane.
  function automatic int lane_slot(input int lane, input bit is_b);
    return 2 * lane + (is_b ? 1 : 0);
  endfunction

  // LSB position of a slot in a packed bus of width-bit slots.
  function automatic int slot_lo(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cas_kv_pair.sv
// cas_kv_pair: combinational compare-and-swap of one key/index pair.
// Equal keys never swap, which keeps the sort stable.
`default_nettype none

module cas_kv_pair #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 3,
  parameter int SIGNED_KEYS = 0
) (
  input  logic [DATA_WIDTH-1:0]  a_key,
  input  logic [INDEX_WIDTH-1:0] a_idx,
  input  logic [DATA_WIDTH-1:0]  b_key,
  input  logic [INDEX_WIDTH-1:0] b_idx,
  input  logic                   dir,
  output logic [DATA_WIDTH-1:0]  x_key,
  output logic [INDEX_WIDTH-1:0] x_idx,
  output logic [DATA_WIDTH-1:0]  y_key,
  output logic [INDEX_WIDTH-1:0] y_idx
);

  logic a_gt_b;
  logic a_lt_b;
  logic swap;

  generate
    if (SIGNED_KEYS != 0) begin : g_signed
      assign a_gt_b = $signed(a_key) > $signed(b_key);
      assign a_lt_b = $signed(a_key) < $signed(b_key);
    end else begin : g_unsigned
      assign a_gt_b = a_key > b_key;
      assign a_lt_b = a_key < b_key;
    end
  endgenerate

  // Ascending puts the smaller key in x; descending puts the larger key in x.
  assign swap  = dir ? a_gt_b : a_lt_b;
  assign x_key = swap ? b_key : a_key;
  assign x_idx = swap ? b_idx : a_idx;
  assign y_key = swap ? a_key : b_key;
  assign y_idx = swap ? a_idx : b_idx;

endmodule

`default_nettype wire

// File: rtl/cas_index_stage.sv
// cas_index_stage: N_LANES parallel key/index compare-and-swaps behind a
// registered output with a one-entry skid buffer.
`default_nettype none

module cas_index_stage
  import sorter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int N_LANES     = DEF_N_LANES,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int SIGNED_KEYS = DEF_SIGNED_KEYS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2*N_LANES*DATA_WIDTH-1:0]    in_key,
  input  logic [2*N_LANES*INDEX_WIDTH-1:0]   in_idx,
  input  logic [N_LANES-1:0]                 in_dir,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [2*N_LANES*DATA_WIDTH-1:0]    out_key,
  output logic [2*N_LANES*INDEX_WIDTH-1:0]   out_idx
);

  localparam int KEY_BITS = 2 * N_LANES * DATA_WIDTH;
  localparam int IDX_BITS = 2 * N_LANES * INDEX_WIDTH;

  logic [KEY_BITS-1:0] sort_key;
  logic [IDX_BITS-1:0] sort_idx;
  logic [KEY_BITS-1:0] skid_key;
  logic [IDX_BITS-1:0] skid_idx;
  logic                accept;
  logic                out_free;

  generate
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      localparam int KA = slot_lo(lane_slot(k, 1'b0), DATA_WIDTH);
      localparam int KB = slot_lo(lane_slot(k, 1'b1), DATA_WIDTH);
      localparam int IA = slot_lo(lane_slot(k, 1'b0), INDEX_WIDTH);
      localparam int IB = slot_lo(lane_slot(k, 1'b1), INDEX_WIDTH);

      cas_kv_pair #(
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH),
        .SIGNED_KEYS(SIGNED_KEYS)
      ) u_cas (
        .a_key(in_key[KA +: DATA_WIDTH]),
        .a_idx(in_idx[IA +: INDEX_WIDTH]),
        .b_key(in_key[KB +: DATA_WIDTH]),
        .b_idx(in_idx[IB +: INDEX_WIDTH]),
        .dir  (in_dir[k]),
        .x_key(sort_key[KA +: DATA_WIDTH]),
        .x_idx(sort_idx[IA +: INDEX_WIDTH]),
        .y_key(sort_key[KB +: DATA_WIDTH]),
        .y_idx(sort_idx[IB +: INDEX_WIDTH])
      );
    end
  endgenerate

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // in_ready is itself the inverted skid-occupancy flop, so it never depends
  // combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_key   <= '0;
      out_idx   <= '0;
      skid_key  <= '0;
      skid_idx  <= '0;
      in_ready  <= 1'b1;
    end else if (out_free) begin
      if (!in_ready) begin
        out_key   <= skid_key;
        out_idx   <= skid_idx;
        out_valid <= 1'b1;
        in_ready  <= 1'b1;
      end else if (accept) begin
        out_key   <= sort_key;
        out_idx   <= sort_idx;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_key <= sort_key;
      skid_idx <= sort_idx;
      in_ready <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cas_index_stage.sv
// tb_cas_index_stage: directed vectors, backpressure/reset sequences and a
// randomized stream against unsigned and signed instances.
`default_nettype none

module tb_cas_index_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_key;
  logic [11:0] in_idx;
  logic [1:0]  in_dir;
  logic        out_ready;

  logic        in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [31:0] out_key_u, out_key_s;
  logic [11:0] out_idx_u, out_idx_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cas_index_stage #(.DATA_WIDTH(8), .N_LANES(2), .INDEX_WIDTH(3), .SIGNED_KEYS(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_key(in_key), .in_idx(in_idx), .in_dir(in_dir),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_key(out_key_u), .out_idx(out_idx_u)
  );

  cas_index_stage #(.DATA_WIDTH(8), .N_LANES(2), .INDEX_WIDTH(3), .SIGNED_KEYS(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_key(in_key), .in_idx(in_idx), .in_dir(in_dir),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_key(out_key_s), .out_idx(out_idx_s)
  );

  typedef struct packed {
    logic [31:0] key;
    logic [11:0] idx;
    logic [1:0]  dir;
    logic [31:0] eku;
    logic [11:0] eiu;
    logic [31:0] eks;
    logic [11:0] eis;
  } vec_t;

  typedef struct packed {
    logic [31:0] ku;
    logic [11:0] iu;
    logic [31:0] ks;
    logic [11:0] is;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: offset-binary mapping turns signed order into unsigned order.
  function automatic logic [43:0] model(input logic [31:0] k, input logic [11:0] ix,
                                        input logic [1:0] d, input bit sgn);
    logic [31:0] ok;
    logic [11:0] oi;
    logic [7:0]  a, b, ua, ub;
    logic [2:0]  ia, ib;
    bit          sw;
    for (int l = 0; l < 2; l++) begin
      a  = k[16*l +: 8];
      b  = k[16*l+8 +: 8];
      ia = ix[6*l +: 3];
      ib = ix[6*l+3 +: 3];
      ua = sgn ? (a ^ 8'h80) : a;
      ub = sgn ? (b ^ 8'h80) : b;
      sw = d[l] ? (ua > ub) : (ub > ua);
      ok[16*l +: 8]   = sw ? b : a;
      ok[16*l+8 +: 8] = sw ? a : b;
      oi[6*l +: 3]    = sw ? ib : ia;
      oi[6*l+3 +: 3]  = sw ? ia : ib;
    end
    return {oi, ok};
  endfunction

  task automatic drive(input int i);
    in_key   = vecs[i].key;
    in_idx   = vecs[i].idx;
    in_dir   = vecs[i].dir;
    in_valid = 1'b1;
  endtask

  task automatic check_out(input string name, input int i);
    check({name, " valid"}, {31'd0, out_valid_u}, 32'd1);
    check({name, " key_u"}, out_key_u, vecs[i].eku);
    check({name, " idx_u"}, {20'd0, out_idx_u}, {20'd0, vecs[i].eiu});
    check({name, " key_s"}, out_key_s, vecs[i].eks);
    check({name, " idx_s"}, {20'd0, out_idx_s}, {20'd0, vecs[i].eis});
  endtask

  initial begin
    int sent, got, cyc;
    logic [43:0] mu, ms;
    exp_t e;

    // Ascending example, descending tie, signed corner, mixed directions.
    vecs[0] = '{key: {8'd7, 8'd1, 8'd3, 8'd9}, idx: {3'd3, 3'd2, 3'd1, 3'd0}, dir: 2'b11,
                eku: {8'd7, 8'd1, 8'd9, 8'd3}, eiu: {3'd3, 3'd2, 3'd0, 3'd1},
                eks: {8'd7, 8'd1, 8'd9, 8'd3}, eis: {3'd3, 3'd2, 3'd0, 3'd1}};
    vecs[1] = '{key: {8'd8, 8'd2, 8'd5, 8'd5}, idx: {3'd2, 3'd1, 3'd6, 3'd4}, dir: 2'b00,
                eku: {8'd2, 8'd8, 8'd5, 8'd5}, eiu: {3'd1, 3'd2, 3'd6, 3'd4},
                eks: {8'd2, 8'd8, 8'd5, 8'd5}, eis: {3'd1, 3'd2, 3'd6, 3'd4}};
    vecs[2] = '{key: {8'h01, 8'hFF, 8'hFF, 8'h01}, idx: {3'd3, 3'd2, 3'd1, 3'd0}, dir: 2'b11,
                eku: {8'hFF, 8'h01, 8'hFF, 8'h01}, eiu: {3'd2, 3'd3, 3'd1, 3'd0},
                eks: {8'h01, 8'hFF, 8'h01, 8'hFF}, eis: {3'd3, 3'd2, 3'd0, 3'd1}};
    vecs[3] = '{key: {8'd250, 8'd10, 8'd100, 8'd200}, idx: {3'd3, 3'd0, 3'd7, 3'd5}, dir: 2'b01,
                eku: {8'd10, 8'd250, 8'd200, 8'd100}, eiu: {3'd0, 3'd3, 3'd5, 3'd7},
                eks: {8'd250, 8'd10, 8'd100, 8'd200}, eis: {3'd3, 3'd0, 3'd7, 3'd5}};

    rst = 1'b1; in_valid = 1'b0; in_key = '0; in_idx = '0; in_dir = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'd0, out_valid_u}, 32'd0);
    check("reset out_key", out_key_u, 32'd0);
    check("reset out_idx", {20'd0, out_idx_u}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", {31'd0, in_ready_u}, 32'd1);

    // Table: back-to-back beats, one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(i);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), i);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drained out_valid", {31'd0, out_valid_u}, 32'd0);

    // Backpressure: three beats offered while stalled, then release.
    out_ready = 1'b0;
    drive(0);
    @(negedge clk);
    check("bp in_ready after 1", {31'd0, in_ready_u}, 32'd1);
    drive(1);
    @(negedge clk);
    check("bp in_ready after 2", {31'd0, in_ready_u}, 32'd0);
    check_out("bp hold a", 0);
    drive(2);
    @(negedge clk);
    check("bp in_ready still low", {31'd0, in_ready_u}, 32'd0);
    check_out("bp hold b", 0);
    out_ready = 1'b1;
    @(negedge clk);
    check_out("bp skid out", 1);
    check("bp in_ready back", {31'd0, in_ready_u}, 32'd1);
    @(negedge clk);
    check_out("bp third", 2);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp drained", {31'd0, out_valid_u}, 32'd0);

    // Reset mid-stream with output and skid full.
    out_ready = 1'b0;
    drive(3);
    @(negedge clk);
    drive(0);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid full in_ready", {31'd0, in_ready_u}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", {31'd0, out_valid_u}, 32'd0);
    check("async rst out_key", out_key_u, 32'd0);
    check("async rst out_idx", {20'd0, out_idx_u}, 32'd0);
    check("async rst in_ready", {31'd0, in_ready_u}, 32'd1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no stale beat", {31'd0, out_valid_u | out_valid_s}, 32'd0);
    end

    // Random stream with scoreboard.
    sent = 0; got = 0; cyc = 0;
    while ((sent < 100 || sb.size() > 0) && cyc < 3000) begin
      out_ready = ($urandom_range(0, 1) == 1);
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      in_key    = $urandom;
      if ($urandom_range(0, 3) == 0) in_key[15:8] = in_key[7:0];
      in_idx    = 12'($urandom);
      in_dir    = 2'($urandom);
      if (out_valid_u && out_ready) begin
        if (sb.size() == 0) begin
          check("stream extra beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          got++;
          check("stream key_u", out_key_u, e.ku);
          check("stream idx_u", {20'd0, out_idx_u}, {20'd0, e.iu});
          check("stream key_s", out_key_s, e.ks);
          check("stream idx_s", {20'd0, out_idx_s}, {20'd0, e.is});
        end
      end
      if (in_valid && in_ready_u) begin
        mu = model(in_key, in_idx, in_dir, 1'b0);
        ms = model(in_key, in_idx, in_dir, 1'b1);
        sb.push_back('{ku: mu[31:0], iu: mu[43:32], ks: ms[31:0], is: ms[43:32]});
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    check("stream timeout", {31'd0, cyc >= 3000}, 32'd0);
    check("stream beat count", got, 32'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cas_index_stage.md
CAS_INDEX_STAGE -- requirements
Module: cas_index_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, key width in bits.
REQ-002 Parameter N_LANES, default 4, independent compare-and-swap pairs per beat.
REQ-003 Parameter INDEX_WIDTH, default 3, index tag width in bits.
REQ-004 Parameter SIGNED_KEYS, default 0, 1 = keys compared as two's complement, 0 = unsigned.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  input beat present.
REQ-008 in_ready  out  1  stage can accept an input beat.
REQ-009 in_key  in  2*N_LANES*DATA_WIDTH  lane k: element A at slot 2k, element B at slot 2k+1 (slot s = bits [s*DATA_WIDTH +: DATA_WIDTH]).
REQ-010 in_idx  in  2*N_LANES*INDEX_WIDTH  index tags; same slot packing as in_key.
REQ-011 in_dir  in  N_LANES  per-lane direction; 1 = ascending, 0 = descending.
REQ-012 out_valid  out  1  output beat present.
REQ-013 out_ready  in  1  consumer accepts the output beat.
REQ-014 out_key  out  2*N_LANES*DATA_WIDTH  sorted keys; same packing as in_key.
REQ-015 out_idx  out  2*N_LANES*INDEX_WIDTH  index tags moved with their keys.

Function
REQ-016 A transfer occurs on a cycle with valid and ready both high on the same side; no other cycle changes beat state.
REQ-017 Per lane, ascending: slot 2k gets the smaller key, slot 2k+1 the larger; descending: the reverse.
REQ-018 Each index tag SHALL always leave in the same slot as its key; key/index pairs are never split.
REQ-019 Equal keys: no swap in either direction (A stays in slot 2k); this makes the stage stable.
REQ-020 Comparison uses SIGNED_KEYS. Example with DATA_WIDTH=8: 8'hFF < 8'h01 when signed, and > when unsigned.
REQ-021 in_dir is sampled with the accepted beat; a later change of in_dir does not affect buffered beats.
REQ-022 Latency: an accepted beat appears on out_valid on the next cycle; with out_ready held high, throughput is 1 beat per cycle.
REQ-023 Buffering: one output register plus one skid register; in_ready = NOT skid_full, driven straight from a flop.
REQ-024 Stall: while out_valid=1 and out_ready=0, out_key, out_idx and out_valid are held stable.
REQ-025 If a beat is accepted while the output stalls, it goes into the skid register; in_ready drops on the next cycle.
REQ-026 When the output drains, the skid beat moves to the output register on that edge; in_ready returns high on the next cycle.
REQ-027 Simultaneous input accept and output drain with the skid empty: the new beat goes directly to the output register.
REQ-028 Beats leave in acceptance order; none are dropped or duplicated.

Reset
REQ-029 rst=1 forces out_valid=0, out_key=0, out_idx=0 and skid empty; in_ready=1 from the first cycle after rst deasserts.
REQ-030 rst asserted mid-stream discards all buffered beats; no partial beat is emitted after release.

Structure
REQ-031 A shared package (sorter_pkg) holds the lane/slot slicing helper functions and the default parameter constants shared with the merge units.
REQ-032 Sub-module cas_kv_pair is purely combinational: one compare-swap of a key plus index pair with dir and SIGNED_KEYS. It is instantiated N_LANES times, and the registers live in cas_index_stage only.

Verification (N_LANES=2, DATA_WIDTH=8, INDEX_WIDTH=3, unsigned unless noted)
REQ-033 Ascending: keys {A0=9,B0=3,A1=1,B1=7}, idx {0,1,2,3}, dir=2'b11 -> next cycle out_key {3,9,1,7}, out_idx {1,0,2,3}.
REQ-034 Descending tie: lane0 keys {5,5}, idx {4,6}, dir0=0 -> out_key {5,5}, out_idx {4,6} (no swap); lane1 keys {2,8}, dir1=0 -> out_key {8,2}.
REQ-035 Backpressure: out_ready=0 while 3 beats are offered -> 2 accepted, in_ready low after the second; raise out_ready -> beats emerge in order, in_ready high again one cycle after the skid drains.
REQ-036 Signed: SIGNED_KEYS=1, keys {8'h01,8'hFF}, dir=1 -> out_key {8'hFF,8'h01}; SIGNED_KEYS=0 on the same keys -> {8'h01,8'hFF}.
REQ-037 Reset mid-stream: output and skid both full, pulse rst asynchronously between edges -> out_valid=0 immediately, outputs zero, in_ready=1, no stale beat afterwards.
REQ-038 Streaming: 100 random beats with random dir and out_ready asserted 50% of the time -> scoreboard matches a reference sort per lane, with zero loss or reordering.
